// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the cache refill/write path (master) and the data memory (slave).
interface data_mem_responder_if;
    logic            req_en;
    logic            req_we;
    logic            req_byte;
    logic [31:0]     req_addr;
    logic [0:3][7:0] req_data;
    logic [0:3][7:0] rsp_data;
    logic            rsp_ready;
    logic            busy;

    modport master (
        output req_en, req_we, req_byte, req_addr, req_data,
        input  rsp_data, rsp_ready, busy
    );

    modport slave (
        input  req_en, req_we, req_byte, req_addr, req_data,
        output rsp_data, rsp_ready, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Backing data RAM responder: one word/byte request at a time, big-endian response.
// Latency: rsp_ready is high in the cycle after accept edge + LATENCY; min request period LATENCY+2.
// Backpressure: none; requests are taken only in IDLE, busy marks the non-IDLE window.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 4096,
    parameter int LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    data_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic            we;
        logic            byte_acc;
        logic [AW-1:0]   addr;
        logic [0:3][7:0] data;
    } req_t;

    logic [7:0]      mem [DEPTH_BYTES];
    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    req_t            lat;
    logic            fire;
    logic [AW-1:0]   word_base;
    logic [0:3][7:0] rd_word;
    logic            unused_addr_hi;

    // Address bits above the RAM size are dropped, giving wrap-around addressing.
    assign unused_addr_hi = ^bus.req_addr[31:AW];

    assign fire      = (state == ST_WAIT) && (cnt == '0);
    assign word_base = lat.addr & ~AW'(3);

    always_comb begin
        rd_word = '0;
        if (lat.byte_acc) begin
            rd_word[3] = mem[lat.addr];
        end else begin
            for (int i = 0; i < 4; i++) begin
                rd_word[i] = mem[word_base + AW'(i)];
            end
        end
    end

    // RAM has no reset; a reset during WAIT leaves state IDLE, so fire never commits the write.
    always_ff @(posedge clk) begin
        if (fire && lat.we) begin
            if (lat.byte_acc) begin
                mem[lat.addr] <= lat.data[3];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    mem[word_base + AW'(i)] <= lat.data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            lat           <= '0;
            bus.rsp_ready <= 1'b0;
            bus.busy      <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_en) begin
                        lat      <= '{we:       bus.req_we,
                                      byte_acc: bus.req_byte,
                                      addr:     bus.req_addr[AW-1:0],
                                      data:     bus.req_data};
                        cnt      <= CW'(LATENCY - 1);
                        state    <= ST_WAIT;
                        bus.busy <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state         <= ST_RESP;
                        bus.rsp_ready <= 1'b1;
                        if (!lat.we) begin
                            bus.rsp_data <= rd_word;
                        end
                    end
                end
                ST_RESP: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset-abort and held-request sequences, random ops vs a byte-array model.
module tb_data_mem_responder;

    localparam int DEPTH   = 4096;
    localparam int LATENCY = 4;

    logic clk;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] ref_rsp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model_apply(input bit we, input bit bt,
                                        input logic [31:0] addr, input logic [31:0] d);
        int unsigned a;
        a = addr % DEPTH;
        if (bt) begin
            if (we) ref_mem[a] = d[7:0];
            else    ref_rsp = {24'h0, ref_mem[a]};
        end else begin
            a = a - (a % 4);
            for (int i = 0; i < 4; i++) begin
                if (we) ref_mem[a + i] = d[31 - 8*i -: 8];
                else    ref_rsp[31 - 8*i -: 8] = ref_mem[a + i];
            end
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_req(input bit we, input bit bt, input logic [31:0] addr,
                          input logic [31:0] d, output logic [31:0] rsp);
        int k;
        bus.req_en   = 1'b1;
        bus.req_we   = we;
        bus.req_byte = bt;
        bus.req_addr = addr;
        bus.req_data = d;
        @(posedge clk);
        @(negedge clk);
        bus.req_en   = 1'b0;
        bus.req_we   = 1'($urandom);
        bus.req_byte = 1'($urandom);
        bus.req_addr = $urandom;
        bus.req_data = $urandom;
        chk("busy_after_accept", bus.busy, 1);
        k = 0;
        while (!bus.rsp_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ready_latency", k, LATENCY);
        chk("busy_at_ready", bus.busy, 1);
        rsp = bus.rsp_data;
        @(negedge clk);
        chk("ready_one_cycle", bus.rsp_ready, 0);
        chk("busy_cleared", bus.busy, 0);
        model_apply(we, bt, addr, d);
    endtask

    typedef struct {
        bit          we;
        bit          bt;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] r;
        bit          seen;
        int          pulses, t, last_t;
        bit          prev_busy;

        tbl[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[1] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        tbl[2] = '{1'b0, 1'b1, 32'h0000_0012, 32'h0000_0000, 32'h0000_00BE};
        tbl[3] = '{1'b1, 1'b1, 32'h0000_0011, 32'hAABB_CC55, 32'h0000_00BE};
        tbl[4] = '{1'b0, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'hDE55_BEEF};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_1000, 32'h1234_5678, 32'hDE55_BEEF};
        tbl[6] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678};
        tbl[7] = '{1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'h1234_5678};
        tbl[8] = '{1'b0, 1'b1, 32'h0000_1003, 32'h0000_0000, 32'h0000_0078};

        rst_b        = 1'b0;
        bus.req_en   = 1'b0;
        bus.req_we   = 1'b0;
        bus.req_byte = 1'b0;
        bus.req_addr = '0;
        bus.req_data = '0;
        ref_rsp      = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", bus.rsp_ready, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_rsp_data", bus.rsp_data, 0);
        rst_b = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_req(tbl[i].we, tbl[i].bt, tbl[i].addr, tbl[i].data, r);
            chk($sformatf("vec%0d_rsp_data", i), r, tbl[i].exp);
        end

        // Reset two cycles into a word write to 0x20 must abort it silently.
        bus.req_en   = 1'b1;
        bus.req_we   = 1'b1;
        bus.req_byte = 1'b0;
        bus.req_addr = 32'h20;
        bus.req_data = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        bus.req_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_b = 1'b0;
        #1;
        chk("abort_busy_async", bus.busy, 0);
        chk("abort_rsp_data_async", bus.rsp_data, 0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_ready) seen = 1'b1;
        end
        rst_b   = 1'b1;
        ref_rsp = '0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_ready) seen = 1'b1;
        end
        chk("abort_no_ready", seen, 0);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, r);
        chk("abort_old_contents", r, 32'hCAFE_F00D);

        // req_en held high: a read every LATENCY+2 cycles, addr scrambled while waiting.
        bus.req_en   = 1'b1;
        bus.req_we   = 1'b0;
        bus.req_byte = 1'b0;
        bus.req_addr = 32'h10;
        prev_busy    = 1'b0;
        pulses       = 0;
        t            = 0;
        last_t       = -1;
        while (pulses < 4 && t < 80) begin
            @(negedge clk);
            t++;
            if (bus.rsp_ready) begin
                pulses++;
                chk("held_rsp_data", bus.rsp_data, 32'hDE55_BEEF);
                if (last_t >= 0) chk("held_period", t - last_t, LATENCY + 2);
                last_t       = t;
                bus.req_addr = 32'h10;
                if (pulses == 4) bus.req_en = 1'b0;
            end else if (bus.busy && !prev_busy) begin
                bus.req_addr = 32'h20;
            end
            prev_busy = bus.busy;
        end
        bus.req_en = 1'b0;
        chk("held_pulses", pulses, 4);
        @(negedge clk);
        chk("held_idle_after", bus.busy, 0);
        model_apply(1'b0, 1'b0, 32'h10, 32'h0);

        // Randomized traffic on 0x40..0x7F with random aliasing high address bits.
        for (int i = 0; i < 16; i++) begin
            do_req(1'b1, 1'b0, 32'h40 + 32'(4 * i), $urandom, r);
        end
        repeat (40) begin
            bit          we, bt;
            logic [31:0] addr, off;
            we   = 1'($urandom_range(0, 1));
            bt   = 1'($urandom_range(0, 1));
            off  = 32'h40 + 32'($urandom_range(0, 63));
            addr = ($urandom << $clog2(DEPTH)) | off;
            do_req(we, bt, addr, $urandom, r);
            chk("rand_rsp_data", r, ref_rsp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
